// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer rectangle-fill engine.
package fb_pkg;
  localparam int CORDW_DEF     = 16;
  localparam int FB_WIDTH_DEF  = 160;
  localparam int FB_HEIGHT_DEF = 120;
  localparam int FB_ADDRW_DEF  = 15;

  typedef logic signed [CORDW_DEF-1:0] coord_t;

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} fill_state_t;
endpackage

// File: rtl/fb_clip_sort.sv
// Orders a pair of corners and clips them to the framebuffer; flags an empty result.
module fb_clip_sort #(
  parameter int CORDW     = 16,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120
) (
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] xa,
  output logic signed [CORDW-1:0] xb,
  output logic signed [CORDW-1:0] ya,
  output logic signed [CORDW-1:0] yb,
  output logic                    empty
);
  localparam logic signed [CORDW-1:0] XLIM = CORDW'(FB_WIDTH - 1);
  localparam logic signed [CORDW-1:0] YLIM = CORDW'(FB_HEIGHT - 1);

  logic signed [CORDW-1:0] xlo, xhi, ylo, yhi;

  always_comb begin
    xlo = (x0 < x1) ? x0 : x1;
    xhi = (x0 < x1) ? x1 : x0;
    ylo = (y0 < y1) ? y0 : y1;
    yhi = (y0 < y1) ? y1 : y0;
    // Negative low edge clamps to 0; a fully off-screen span ends up inverted.
    xa = xlo[CORDW-1] ? '0 : xlo;
    ya = ylo[CORDW-1] ? '0 : ylo;
    xb = (xhi > XLIM) ? XLIM : xhi;
    yb = (yhi > YLIM) ? YLIM : yhi;
    empty = (xa > xb) || (ya > yb);
  end
endmodule

// File: rtl/fb_rect_fill.sv
// Fills a clipped, corner-normalised rectangle into the framebuffer write port,
// one pixel per output-enabled cycle, with a start/busy/done handshake.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int CORDW     = CORDW_DEF,
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int FB_ADDRW  = FB_ADDRW_DEF,
  parameter int FB_DATAW  = 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic [FB_DATAW-1:0]     colr,
  output logic                    busy,
  output logic                    done,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr_write,
  output logic [FB_DATAW-1:0]     fb_colr_write
);
  localparam int AW1 = FB_ADDRW + 1;
  localparam logic [FB_ADDRW:0] WSTEP = AW1'(FB_WIDTH);

  fill_state_t state, state_n;

  logic signed [CORDW-1:0] cx0, cy0, cx1, cy1;
  logic signed [CORDW-1:0] xa_c, xb_c, ya_c, yb_c;
  logic                    empty;
  logic signed [CORDW-1:0] xa_r, xb_r, yb_r, x, y;
  logic [FB_ADDRW-1:0]     row_base, addr;
  logic [FB_DATAW-1:0]     colour;
  logic                    row_end, last;
  logic [FB_ADDRW:0]       base_init, sum_init, base_next, sum_next_row, sum_next_x;

  fb_clip_sort #(.CORDW(CORDW), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) u_clip (
    .x0(cx0), .y0(cy0), .x1(cx1), .y1(cy1),
    .xa(xa_c), .xb(xb_c), .ya(ya_c), .yb(yb_c), .empty(empty)
  );

  // Clipped coordinates are non-negative, so the wide sums never overflow.
  assign base_init    = AW1'(ya_c) * WSTEP;
  assign sum_init     = base_init + AW1'(xa_c);
  assign base_next    = AW1'(row_base) + WSTEP;
  assign sum_next_row = base_next + AW1'(xa_r);
  assign sum_next_x   = AW1'(row_base) + AW1'(x) + AW1'(1);

  assign row_end = (x == xb_r);
  assign last    = row_end && (y == yb_r);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = INIT;
      INIT:    state_n = empty ? DONE : DRAW;
      DRAW:    if (oe && last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      cx0 <= '0; cy0 <= '0; cx1 <= '0; cy1 <= '0;
      xa_r <= '0; xb_r <= '0; yb_r <= '0;
      x <= '0; y <= '0;
      row_base <= '0; addr <= '0; colour <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cx0 <= x0; cy0 <= y0; cx1 <= x1; cy1 <= y1;
          colour <= colr;
        end
        INIT: begin
          xa_r <= xa_c; xb_r <= xb_c; yb_r <= yb_c;
          x <= xa_c; y <= ya_c;
          row_base <= FB_ADDRW'(base_init);
          addr     <= FB_ADDRW'(sum_init);
        end
        DRAW: if (oe && !last) begin
          if (row_end) begin
            x <= xa_r;
            y <= y + CORDW'(1);
            row_base <= FB_ADDRW'(base_next);
            addr     <= FB_ADDRW'(sum_next_row);
          end else begin
            x <= x + CORDW'(1);
            addr <= FB_ADDRW'(sum_next_x);
          end
        end
        default: ;
      endcase
    end
  end

  // Address and colour are held in registers; oe gates the strobe in the same
  // cycle so a stalled cycle never issues a write.
  assign fb_we         = (state == DRAW) && oe;
  assign fb_addr_write = addr;
  assign fb_colr_write = colour;
  assign busy          = (state == INIT) || (state == DRAW);
  assign done          = (state == DONE);
endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomised and directed checks of fb_rect_fill against a pixel-list reference model.
module tb_fb_rect_fill;
  import fb_pkg::*;

  localparam int W = 160;
  localparam int H = 120;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n = 1'b0;
  logic        start = 1'b0;
  logic        oe = 1'b1;
  coord_t      x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [0:0]  colr = '0;
  logic        busy, done, fb_we;
  logic [14:0] fb_addr_write;
  logic [0:0]  fb_colr_write;

  int ncmp = 0;
  int nerr = 0;
  int expq[$];

  always #5 clk_pix = ~clk_pix;

  fb_rect_fill dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .start(start), .oe(oe),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colr(colr),
    .busy(busy), .done(done), .fb_we(fb_we),
    .fb_addr_write(fb_addr_write), .fb_colr_write(fb_colr_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the ordered list of pixel addresses the rectangle should produce.
  task automatic build(input int ax0, input int ay0, input int ax1, input int ay1);
    int lx, hx, ly, hy;
    expq.delete();
    lx = (ax0 < ax1) ? ax0 : ax1;  hx = (ax0 < ax1) ? ax1 : ax0;
    ly = (ay0 < ay1) ? ay0 : ay1;  hy = (ay0 < ay1) ? ay1 : ay0;
    if (lx < 0) lx = 0;
    if (ly < 0) ly = 0;
    if (hx > W-1) hx = W-1;
    if (hy > H-1) hy = H-1;
    for (int yy = ly; yy <= hy; yy++)
      for (int xx = lx; xx <= hx; xx++)
        expq.push_back(yy*W + xx);
  endtask

  // mode 0: oe always high; 1: random oe; 2: oe pattern 1,0,0,1 then high.
  // poke: extra start pulses during DRAW and during DONE, both to be ignored.
  task automatic run_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic c, input int mode, input bit poke);
    int lim;
    bit fin;
    build(ax0, ay0, ax1, ay1);
    lim = expq.size()*6 + 40;
    fin = 1'b0;
    @(negedge clk_pix);
    x0 = coord_t'(ax0); y0 = coord_t'(ay0); x1 = coord_t'(ax1); y1 = coord_t'(ay1);
    colr = c; oe = 1'b1; start = 1'b1;
    @(negedge clk_pix);
    start = 1'b0;
    #1;
    chk("init_busy", busy, 1);
    chk("init_we", fb_we, 0);
    chk("init_done", done, 0);
    for (int k = 2; k < lim && !fin; k++) begin
      @(negedge clk_pix);
      case (mode)
        1:       oe = ($urandom_range(0, 3) != 0);
        2:       oe = !(k == 3 || k == 4);
        default: oe = 1'b1;
      endcase
      start = poke && (k == 3 || expq.size() == 0);
      if (poke && k == 3) begin
        x0 = 16'sd40; y0 = 16'sd40; x1 = 16'sd50; y1 = 16'sd50;
      end
      #1;
      if (expq.size() == 0) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_we", fb_we, 0);
        fin = 1'b1;
      end else begin
        chk("draw_busy", busy, 1);
        chk("draw_done", done, 0);
        chk("draw_we", fb_we, oe);
        if (oe) begin
          chk("draw_addr", fb_addr_write, expq[0]);
          chk("draw_colr", fb_colr_write, c);
          void'(expq.pop_front());
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(negedge clk_pix);
    start = 1'b0; oe = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_we", fb_we, 0);
  endtask

  initial begin
    int rx, ry;
    repeat (3) @(negedge clk_pix);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr_write, 0);
    chk("rst_colr", fb_colr_write, 0);
    rst_pix_n = 1'b1;

    run_rect(10, 5, 11, 6, 1'b1, 0, 1'b0);
    run_rect(11, 6, 10, 5, 1'b1, 0, 1'b0);
    run_rect(-3, -2, 1, 0, 1'b1, 0, 1'b0);
    run_rect(158, 119, 200, 300, 1'b1, 0, 1'b0);
    run_rect(170, 10, 180, 20, 1'b1, 0, 1'b0);
    run_rect(-5, -5, -1, -1, 1'b1, 0, 1'b0);
    run_rect(0, 0, 2, 0, 1'b1, 2, 1'b1);
    run_rect(7, 7, 7, 7, 1'b1, 0, 1'b0);
    run_rect(159, 60, 159, 62, 1'b0, 1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rx = int'($urandom_range(0, 200)) - 20;
      ry = int'($urandom_range(0, 160)) - 20;
      run_rect(rx, ry, rx + int'($urandom_range(0, 24)) - 12,
               ry + int'($urandom_range(0, 16)) - 8,
               1'($urandom_range(0, 1)), 1, (i % 3) == 0);
    end

    // Reset during a full-screen clear.
    @(negedge clk_pix);
    x0 = 0; y0 = 0; x1 = 16'sd159; y1 = 16'sd119; colr = 1'b0; oe = 1'b1; start = 1'b1;
    @(negedge clk_pix);
    start = 1'b0;
    repeat (100) @(negedge clk_pix);
    #1;
    chk("mid_we", fb_we, 1);
    #1;
    rst_pix_n = 1'b0;
    #1;
    chk("arst_we", fb_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", fb_addr_write, 0);
    chk("arst_colr", fb_colr_write, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_pix);
      #1;
      chk("arst_hold_done", done, 0);
      chk("arst_hold_we", fb_we, 0);
    end
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(negedge clk_pix);
    #1;
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);

    run_rect(0, 0, 159, 119, 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
